rgb_fader: RTL
==============

# rgb_fader

Memory-mapped colour-fade engine on the PicoSoC iomem bus, directly upstream of the `pwm` RGB driver. Software writes a target colour and a step rate; the block ramps three 8-bit duty values one LSB per tick toward the target and drives them straight into `pwm_r`/`pwm_g`/`pwm_b`. It raises a sticky `done` flag when all three channels reach their targets.

## Interface
- `ADDR_HI`, 8'h04: iomem window select; the block responds when `iomem_addr[31:24] == ADDR_HI`.
- `RATE_RESET`, 16'd1000: reset value of the RATE register.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous and active-high.
- `iomem_valid`  in  1  bus request.
- `iomem_ready`  out  1  one-cycle acknowledge.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_rdata`  out  32  registered read data.
- `duty_r`, `duty_g`, `duty_b`  out  8 each  current duty values, to `pwm`.
- `busy`  out  1  high while any current value differs from its target.
- `done`  out  1  sticky completion flag, usable as an IRQ.

## Operation
Register map, decoded on `iomem_addr[7:0]`:
- **0x00 TARGET** (RW): R in [7:0], G in [15:8], B in [23:16]. Bits [31:24] read 0.
- **0x04 CURRENT** (RW): same layout. A read returns the live duty values. A write jumps the channel immediately.
- **0x08 RATE** (RW): [15:0] holds the prescaler terminal count. Any write to RATE also clears the prescaler.
- **0x0C STATUS**: bit0 = `busy` (RO), bit1 = `done` (write 1 to clear). Other bits read 0.

Access rules:
- Writes honour `iomem_wstrb` per byte. Strobes on unused bytes are ignored.
- Unmapped offsets inside the window: the block acks, returns `rdata` = 0, and ignores the write.
- Addresses outside the window get no response; `iomem_ready` stays 0.

Prescaler:
- Counter `pc` counts 0..RATE. `tick` is high for one cycle when `pc == RATE`, and `pc` then wraps to 0.
- RATE = 0 gives a tick every cycle.

Stepping:
- On each `tick`, each channel with current < target increments by 1, and each with current > target decrements by 1. Channels never overshoot or wrap.
- Stepping uses the target value held before any same-cycle TARGET write.
- A CURRENT write to a byte takes priority over a tick step for that channel in the same cycle.

Flags:
- `busy` is combinational: (cur_r != tgt_r) | (cur_g != tgt_g) | (cur_b != tgt_b).
- `done` sets on the cycle after `busy` goes 1→0, whatever the cause (tick or CURRENT write).
- If a set event and a W1C happen in the same cycle, the set wins.

Reset values: all targets and currents 0, RATE = RATE_RESET, `pc` = 0, `done` = 0, `iomem_ready` = 0, `iomem_rdata` = 0. This gives `duty_*` = 0 and `busy` = 0.

## Timing
Bus handshake:
- Request accepted when `iomem_valid & !iomem_ready & window hit`.
- `iomem_ready` goes high on the next edge for exactly one cycle. `iomem_rdata` is valid in that same cycle.
- Register writes take effect on the same edge that raises `iomem_ready`.
- One transaction per two cycles, maximum.

Ramp timing:
- Duty outputs are registered. A step becomes visible the cycle after `tick`.
- A full 0→255 ramp takes 255 × (RATE+1) cycles.

Reset mid-operation:
- `rst` asserted during a ramp or a bus cycle forces all reset values on the next edge.
- An in-flight request is dropped with no ack.

## Test plan
1. **Reset.** Hold `rst` for 2 cycles, then read 0x08 → `rdata` = 1000 with `ready` high for exactly one cycle; `duty_*` = 0, `busy` = 0, `done` = 0.
2. **Upward ramp.**
   - Write RATE = 3, then TARGET = 0x000004.
   - `duty_r` steps 0→4, one step every 4 cycles; `busy` is high throughout and falls after the 4th step.
   - `done` rises the cycle after `busy` falls; reading STATUS returns 0x2.
3. **Down/mixed ramp and W1C.**
   - Write CURRENT = 0x0A0005 and TARGET = 0x080007 with RATE = 0.
   - `duty_r` goes 5→6→7 and `duty_b` goes 10→9→8 on consecutive cycles; `duty_g` stays 0.
   - Writing STATUS = 0x2 clears `done`.
4. **Byte strobes.** With TARGET = 0x112233, write 0x00AA0000 using `wstrb` = 4'b0100 → TARGET reads 0xAA2233.
5. **Collision.** At RATE = 0, write CURRENT R = 0x80 in the same cycle a tick would step R → `duty_r` = 0x80, with no ±1 applied that cycle.
6. **Decode.**
   - Access 0x04000010 → ack with `rdata` = 0 and no state change.
   - Access 0x03000000 → `iomem_ready` stays 0 for 8 cycles.
   - Assert `rst` mid-ramp → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/rgb_fader.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fader
// Purpose  : Memory-mapped colour-fade engine on the PicoSoC iomem bus. Ramps
//            three 8-bit duty values one LSB per prescaler tick toward a
//            software-written target and feeds them to the pwm RGB driver.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            iomem_valid/ready        - bus request / one-cycle acknowledge
//            iomem_wstrb/addr/wdata   - write strobes (0 = read), address, data
//            iomem_rdata              - registered read data
//            duty_r/g/b               - current duty values to pwm
//            busy                     - any channel differs from its target
//            done                     - sticky completion flag (W1C)
// Revision : 1.0 - initial release
// ============================================================================
module rgb_fader #(
  parameter logic [7:0]  ADDR_HI    = 8'h04,
  parameter logic [15:0] RATE_RESET = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  duty_r,
  output logic [7:0]  duty_g,
  output logic [7:0]  duty_b,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] C_OFF_TARGET  = 8'h00;
  localparam logic [7:0] C_OFF_CURRENT = 8'h04;
  localparam logic [7:0] C_OFF_RATE    = 8'h08;
  localparam logic [7:0] C_OFF_STATUS  = 8'h0C;

  // Channel packing in tgt/cur: R [7:0], G [15:8], B [23:16]
  logic [23:0] tgt_q, tgt_d;
  logic [23:0] cur_q, cur_d;
  logic [15:0] rate_q, rate_d;
  logic [15:0] pc_q, pc_d;
  logic        done_q, done_d;
  logic        busy_prev_q, busy_prev_d;
  logic        iomem_ready_q, iomem_ready_d;
  logic [31:0] iomem_rdata_q, iomem_rdata_d;

  logic        req;
  logic        wr;
  logic        wr_tgt, wr_cur, wr_rate, wr_stat;
  logic        tick;
  logic [7:0]  off;
  logic [7:0]  ch_cur, ch_tgt;
  logic [31:0] rd_mux;

  // Address and data bits that play no part in decode or storage
  logic        unused_bits;
  assign unused_bits = &{1'b0, iomem_addr[23:8], iomem_wdata[31:24]};

  assign busy = (cur_q[7:0]   != tgt_q[7:0])  |
                (cur_q[15:8]  != tgt_q[15:8]) |
                (cur_q[23:16] != tgt_q[23:16]);

  always_comb begin
    off     = iomem_addr[7:0];
    // ready_q masks the request so each accepted access yields a single ack
    req     = iomem_valid & ~iomem_ready_q & (iomem_addr[31:24] == ADDR_HI);
    wr      = req & (|iomem_wstrb);
    wr_tgt  = wr & (off == C_OFF_TARGET);
    wr_cur  = wr & (off == C_OFF_CURRENT);
    wr_rate = wr & (off == C_OFF_RATE);
    wr_stat = wr & (off == C_OFF_STATUS);

    tick    = (pc_q == rate_q);

    tgt_d   = tgt_q;
    cur_d   = cur_q;
    ch_cur  = 8'd0;
    ch_tgt  = 8'd0;
    for (int i = 0; i < 3; i++) begin
      ch_cur = cur_q[8*i +: 8];
      ch_tgt = tgt_q[8*i +: 8];
      // Step against the pre-write target; a CURRENT write to this byte wins
      if (tick) begin
        if (ch_cur < ch_tgt) begin
          cur_d[8*i +: 8] = ch_cur + 8'd1;
        end else if (ch_cur > ch_tgt) begin
          cur_d[8*i +: 8] = ch_cur - 8'd1;
        end
      end
      if (wr_cur && iomem_wstrb[i]) begin
        cur_d[8*i +: 8] = iomem_wdata[8*i +: 8];
      end
      if (wr_tgt && iomem_wstrb[i]) begin
        tgt_d[8*i +: 8] = iomem_wdata[8*i +: 8];
      end
    end

    rate_d = rate_q;
    if (wr_rate && iomem_wstrb[0]) rate_d[7:0]  = iomem_wdata[7:0];
    if (wr_rate && iomem_wstrb[1]) rate_d[15:8] = iomem_wdata[15:8];

    // Any RATE write restarts the prescaler so the new period starts cleanly
    pc_d = (tick || wr_rate) ? 16'd0 : pc_q + 16'd1;

    busy_prev_d = busy;
    done_d      = done_q;
    if (wr_stat && iomem_wstrb[0] && iomem_wdata[1]) done_d = 1'b0;
    // Set after the W1C so a coincident completion is never lost
    if (busy_prev_q && !busy) done_d = 1'b1;

    case (off)
      C_OFF_TARGET:  rd_mux = {8'd0, tgt_q};
      C_OFF_CURRENT: rd_mux = {8'd0, cur_q};
      C_OFF_RATE:    rd_mux = {16'd0, rate_q};
      C_OFF_STATUS:  rd_mux = {30'd0, done_q, busy};
      default:       rd_mux = 32'd0;
    endcase

    iomem_ready_d = req;
    iomem_rdata_d = req ? rd_mux : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q         <= 24'd0;
      cur_q         <= 24'd0;
      rate_q        <= RATE_RESET;
      pc_q          <= 16'd0;
      done_q        <= 1'b0;
      busy_prev_q   <= 1'b0;
      iomem_ready_q <= 1'b0;
      iomem_rdata_q <= 32'd0;
    end else begin
      tgt_q         <= tgt_d;
      cur_q         <= cur_d;
      rate_q        <= rate_d;
      pc_q          <= pc_d;
      done_q        <= done_d;
      busy_prev_q   <= busy_prev_d;
      iomem_ready_q <= iomem_ready_d;
      iomem_rdata_q <= iomem_rdata_d;
    end
  end

  assign iomem_ready = iomem_ready_q;
  assign iomem_rdata = iomem_rdata_q;
  assign duty_r      = cur_q[7:0];
  assign duty_g      = cur_q[15:8];
  assign duty_b      = cur_q[23:16];
  assign done        = done_q;

endmodule
`default_nettype wire
